// File: rtl/ser_tx.sv
// rtl/ser_tx.sv - double-buffered parallel-to-serial transmitter with per-word done strobe
module ser_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = 1'b0
) (
    input  logic             clk_i,
    input  logic             res_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             bit_en_i,
    output logic             w_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam int unsigned      CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t           state_q;
    logic             hold_full_q;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    bitcnt_q;
    logic             w_q;
    logic             done_q;

    logic             accept;
    logic             head_bit;
    logic [WIDTH-1:0] shreg_d;

    // Ready depends only on state and reset, never on valid_i.
    assign ready_o = !hold_full_q && !res_i;
    assign accept  = valid_i && ready_o;
    assign busy_o  = (state_q == ST_SHIFT) || hold_full_q;
    assign w_o     = w_q;
    assign done_o  = done_q;

    // Head bit to emit next and the shift register advanced toward the head.
    always_comb begin
        head_bit = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
        shreg_d  = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
    end

    // Handshake capture, IDLE/SHIFT sequencing and registered serial outputs.
    always_ff @(posedge clk_i) begin
        if (res_i) begin
            state_q     <= ST_IDLE;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            w_q         <= IDLE_BIT;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Accept and the hold->shreg transfers below are mutually exclusive:
            // accept needs hold empty, a transfer needs hold full.
            if (accept) begin
                hold_q      <= data_i;
                hold_full_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bit_en_i) begin
                        w_q <= IDLE_BIT;
                    end
                    // Loading the shifter does not wait for a bit strobe.
                    if (hold_full_q) begin
                        shreg_q     <= hold_q;
                        hold_full_q <= 1'b0;
                        bitcnt_q    <= '0;
                        state_q     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bit_en_i) begin
                        w_q      <= head_bit;
                        shreg_q  <= shreg_d;
                        bitcnt_q <= bitcnt_q + CW'(1);
                        if (bitcnt_q == LAST) begin
                            done_q <= 1'b1;
                            // Reload directly so the next word follows with no gap.
                            if (hold_full_q) begin
                                shreg_q     <= hold_q;
                                hold_full_q <= 1'b0;
                                bitcnt_q    <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ser_tx.sv
// tb/tb_ser_tx.sv - randomized and directed bench for ser_tx against a queue-based reference
module tb_ser_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         res = 1'b1;
    logic         valid = 1'b0;
    logic         bit_en = 1'b0;
    logic [W-1:0] data = '0;

    logic rdy_l, w_l, done_l, busy_l;
    logic rdy_m, w_m, done_m, busy_m;

    always #5 clk = ~clk;

    ser_tx #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_lsb (
        .clk_i(clk), .res_i(res), .data_i(data), .valid_i(valid), .ready_o(rdy_l),
        .bit_en_i(bit_en), .w_o(w_l), .done_o(done_l), .busy_o(busy_l)
    );

    ser_tx #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_msb (
        .clk_i(clk), .res_i(res), .data_i(data), .valid_i(valid), .ready_o(rdy_m),
        .bit_en_i(bit_en), .w_o(w_m), .done_o(done_m), .busy_o(busy_m)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: one pending word slot plus a queue of bits still to be sent
    // (one queue per bit order). An empty bit queue means the line is idle.
    bit         pend_full = 1'b0;
    bit [W-1:0] pend_word = '0;
    bit         q_l[$];
    bit         q_m[$];
    bit         exp_w_l = 1'b0;
    bit         exp_w_m = 1'b1;
    bit         exp_done = 1'b0;
    bit         acc_last = 1'b0;
    int         cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic load_word(input bit [W-1:0] word);
        for (int k = 0; k < W; k++) begin
            q_l.push_back(word[k]);
            q_m.push_back(word[W-1-k]);
        end
    endtask

    task automatic model_edge(input bit v, input bit [W-1:0] d, input bit be, input bit r);
        bit acc;
        acc = v && !pend_full && !r;
        exp_done = 1'b0;
        if (r) begin
            pend_full = 1'b0;
            q_l.delete();
            q_m.delete();
            exp_w_l = 1'b0;
            exp_w_m = 1'b1;
        end else begin
            if (q_l.size() == 0) begin
                if (be) begin
                    exp_w_l = 1'b0;
                    exp_w_m = 1'b1;
                end
                if (pend_full) begin
                    load_word(pend_word);
                    pend_full = 1'b0;
                end
            end else if (be) begin
                exp_w_l = q_l.pop_front();
                exp_w_m = q_m.pop_front();
                if (q_l.size() == 0) begin
                    exp_done = 1'b1;
                    if (pend_full) begin
                        load_word(pend_word);
                        pend_full = 1'b0;
                    end
                end
            end
            if (acc) begin
                pend_full = 1'b1;
                pend_word = d;
            end
        end
        acc_last = acc;
    endtask

    task automatic cycle(input bit v, input bit [W-1:0] d, input bit be, input bit r);
        bit exp_busy;
        @(negedge clk);
        valid  = v;
        data   = d;
        bit_en = be;
        res    = r;
        #1;
        check("ready_l", rdy_l, !pend_full && !r);
        check("ready_m", rdy_m, !pend_full && !r);
        @(posedge clk);
        model_edge(v, d, be, r);
        #1;
        exp_busy = (q_l.size() != 0) || pend_full;
        check("w_l", w_l, exp_w_l);
        check("w_m", w_m, exp_w_m);
        check("done_l", done_l, exp_done);
        check("done_m", done_m, exp_done);
        check("busy_l", busy_l, exp_busy);
        check("busy_m", busy_m, exp_busy);
        cyc++;
    endtask

    // Send one word from idle with a continuous strobe and reassemble both streams.
    task automatic send_collect(input bit [W-1:0] word);
        bit [W-1:0] col_l;
        bit [W-1:0] col_m;
        int         done_at;
        int         done_cnt;
        col_l = '0;
        col_m = '0;
        done_at = 0;
        done_cnt = 0;
        cycle(1'b1, word, 1'b1, 1'b0);
        for (int k = 1; k <= W + 2; k++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            if (k >= 2 && k <= W + 1) begin
                col_l[k-2] = w_l;
                col_m = {col_m[W-2:0], w_m};
            end
            if (done_l) begin
                done_at = k;
                done_cnt++;
            end
        end
        check("word_lsb", col_l, word);
        check("word_msb", col_m, word);
        check("done_edge", done_at, W + 1);
        check("done_cnt", done_cnt, 1);
        check("idle_l", w_l, 1'b0);
        check("idle_m", w_m, 1'b1);
    endtask

    int         done_cycles[$];
    bit         src_has;
    bit [W-1:0] src_data;
    int         mode;
    bit         be;
    bit         r;

    initial begin
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("rst_busy", busy_l, 1'b0);
        check("rst_w_m", w_m, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Single words, both bit orders.
        send_collect(8'h0F);
        send_collect(8'hA5);

        // Back-to-back words with valid held until accepted.
        done_cycles.delete();
        cycle(1'b1, 8'hFF, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 8'h00, 1'b1, 1'b0);
            if (done_l) done_cycles.push_back(cyc);
            if (acc_last) break;
        end
        for (int k = 0; k < 2 * W + 4; k++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            if (done_l) done_cycles.push_back(cyc);
        end
        check("b2b_done_cnt", done_cycles.size(), 2);
        if (done_cycles.size() == 2)
            check("b2b_done_gap", done_cycles[1] - done_cycles[0], W);

        // Slow strobe, one edge in three.
        done_cycles.delete();
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        for (int k = 0; k < 3 * W + 9; k++) begin
            cycle(1'b0, '0, (k % 3) == 0, 1'b0);
            if (done_l) done_cycles.push_back(cyc);
        end
        check("slow_done_cnt", done_cycles.size(), 1);

        // Reset in the middle of a word.
        cycle(1'b1, 8'hFF, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("midrst_busy", busy_l, 1'b0);
        done_cycles.delete();
        for (int k = 0; k < W + 3; k++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            if (done_l || done_m) done_cycles.push_back(cyc);
        end
        check("midrst_no_done", done_cycles.size(), 0);

        // Randomized traffic with varying strobe patterns and rare resets.
        src_has  = 1'b0;
        src_data = '0;
        for (int seg = 0; seg < 8; seg++) begin
            mode = seg % 3;
            for (int k = 0; k < 400; k++) begin
                if (!src_has && ($urandom_range(3) != 0)) begin
                    src_has  = 1'b1;
                    src_data = W'($urandom);
                end
                case (mode)
                    0:       be = 1'b1;
                    1:       be = (k % 3) == 0;
                    default: be = $urandom_range(1) == 1;
                endcase
                r = ($urandom_range(299) == 0);
                cycle(src_has, src_data, be, r);
                if (acc_last) src_has = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ser_tx.md
Name: ser_tx

Overview:
- Parallel-to-serial transmitter that sits directly upstream of the 4-in-a-row run-detector FSM and drives its serial input bit.
- Accepts WIDTH-bit words over a valid/ready handshake and double-buffers them in a holding register plus a shift register, so back-to-back words stream with no idle bits between them.
- Emits one bit per bit_en_i strobe and flags the last bit of each word.

Parameters:
- WIDTH, 8, word width in bits; legal range is 2 to 32.
- LSB_FIRST, 1, when 1 bit 0 is sent first; when 0 bit WIDTH-1 is sent first.
- IDLE_BIT, 0, level driven on w_o when no word is being shifted.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- res_i  input  1  reset; synchronous, active-high.
- data_i  input  WIDTH  parallel word to transmit.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  holding register is empty; a word is accepted on an edge where valid_i and ready_o are both 1.
- bit_en_i  input  1  bit-rate strobe; w_o advances only on edges where this is 1.
- w_o  output  1  registered serial output bit.
- done_o  output  1  one-cycle pulse on the edge that puts the last bit of a word on w_o.
- busy_o  output  1  the shift register is active or the holding register is full.

Behaviour:
- Reset: on an edge with res_i=1, all state is cleared:
  - state <= IDLE, hold_full <= 0, bitcnt <= 0, shreg <= 0, hold <= 0.
  - w_o <= IDLE_BIT, done_o <= 0.
  - ready_o is 0 whenever res_i=1 and 1 on the first cycle after reset.
  - A word that was partly shifted when reset arrived is discarded; no done_o is issued for it.
- Handshake:
  - ready_o = !hold_full && !res_i. It is decoded from registers only, never from valid_i.
  - On accept, hold <= data_i and hold_full <= 1.
  - While valid_i=1 and ready_o=0, data is not captured; the upstream source holds it.
- State machine with two states, IDLE and SHIFT. bitcnt is $clog2(WIDTH) bits wide.
- IDLE:
  - If hold_full: shreg <= hold, hold_full <= 0, bitcnt <= 0, go to SHIFT. This transfer ignores bit_en_i.
  - Whenever bit_en_i=1 in IDLE, w_o <= IDLE_BIT.
- SHIFT, on edges with bit_en_i=1:
  - w_o <= the current head bit: shreg[0] if LSB_FIRST, else shreg[WIDTH-1].
  - shreg shifts toward the head by one; bitcnt increments.
- Last bit (bitcnt == WIDTH-1 and bit_en_i=1):
  - done_o <= 1 for that edge only.
  - If hold_full: reload shreg <= hold, hold_full <= 0, bitcnt <= 0, stay in SHIFT. This gives gapless streaming.
  - Otherwise go to IDLE; w_o holds the last bit until the next bit_en_i edge, which drives IDLE_BIT.
- On SHIFT edges with bit_en_i=0, nothing changes: w_o, shreg and bitcnt hold and done_o=0.
- Simultaneous events: an accept on the same edge as a last-bit reload cannot happen, because ready_o=0 while hold_full=1. An accept on a last-bit edge with hold empty is captured into hold. SHIFT is then exited to IDLE, which loads the word on the next edge, leaving one extra cycle (not one bit time) before its bit 0.
- Latency with bit_en_i tied to 1: a word accepted at edge N reaches shreg at N+1. Its bit 0 appears on w_o after edge N+2, its last bit after edge N+1+WIDTH, with done_o high in that same cycle.
- busy_o = (state == SHIFT) || hold_full, registered-decoded.

Test Plan:
1. WIDTH=8, LSB_FIRST=1, bit_en_i=1, send 0x0F at edge N -> w_o = 1,1,1,1,0,0,0,0 on edges N+2..N+9; done_o high only after N+9; w_o=0 after N+10.
2. valid_i held with 0xFF then 0x00 -> 16 contiguous bits (eight 1s then eight 0s) with no IDLE_BIT gap; ready_o low from second accept until first reload; done_o pulses exactly twice, 8 edges apart.
3. LSB_FIRST=0, send 0xA5 -> w_o = 1,0,1,0,0,1,0,1.
4. bit_en_i high 1 cycle in 3, send 0x3C -> each bit held on w_o exactly 3 cycles; done_o a single 1-cycle pulse on the strobe edge of the 8th bit.
5. res_i asserted for 1 cycle after 3 bits of 0xFF -> w_o=IDLE_BIT, ready_o=0 during reset, ready_o=1 next cycle, busy_o=0, no done_o.
6. Hold full while shifting, present 0x55 with valid_i=1 -> not captured while ready_o=0; value transmitted afterward is the previously held word, then 0x55 once ready_o rises.
